// File: rtl/slow_tick_pkg.sv
// Shared types and constants for the programmable slow tick generator.
package slow_tick_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    localparam int MIN_DIV     = 2;
    localparam int DEFAULT_DIV = 250000;
    localparam int PKG_DIV_W   = 32;

    // Periods below two cycles cannot produce both a low and a high half.
    function automatic logic [PKG_DIV_W-1:0] clamp_div(input logic [PKG_DIV_W-1:0] div);
        return (div < PKG_DIV_W'(MIN_DIV)) ? PKG_DIV_W'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/slow_tick_if.sv
// Control/status bundle of slow_tick_ctrl; burst ports exist only with SLOW_TICK_BURST_EN.
interface slow_tick_if #(
    parameter int DIV_W = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             step;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic             tick;
    logic             slow_en;
    logic             busy;
    logic [CNT_W-1:0] tick_count;
`ifdef SLOW_TICK_BURST_EN
    logic [CNT_W-1:0] burst_len;
    logic             burst_done;

    modport master (output start, stop, step, cfg_valid, cfg_div, burst_len,
                    input  cfg_ready, tick, slow_en, busy, tick_count, burst_done);
    modport slave  (input  start, stop, step, cfg_valid, cfg_div, burst_len,
                    output cfg_ready, tick, slow_en, busy, tick_count, burst_done);
`else
    modport master (output start, stop, step, cfg_valid, cfg_div,
                    input  cfg_ready, tick, slow_en, busy, tick_count);
    modport slave  (input  start, stop, step, cfg_valid, cfg_div,
                    output cfg_ready, tick, slow_en, busy, tick_count);
`endif
endinterface

// File: rtl/slow_tick_phase.sv
// Phase counter 0..P-1 with its period register, terminal-count and half-period compares.
module slow_tick_phase #(
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             tc,
    output logic             hi
);
    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] period;

    assign tc = (phase == period - DIV_W'(1));
    assign hi = (phase >= (period >> 1));

    // A new period loaded on the wrap edge governs the phase that starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= '0;
            period <= DIV_W'(DEFAULT_DIV);
        end else begin
            if (load)
                period <= load_div;
            if (clear)
                phase <= '0;
            else if (en)
                phase <= tc ? '0 : phase + DIV_W'(1);
        end
    end

endmodule

// File: rtl/slow_tick_ctrl.sv
// Start/stop/step tick generator with shadowed divisor; SLOW_TICK_BURST_EN adds auto-stop bursts.
module slow_tick_ctrl #(
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = slow_tick_pkg::DEFAULT_DIV,
    parameter int CNT_W       = 16
) (
    input logic       clk,
    input logic       rst,
    slow_tick_if.slave bus
);
    import slow_tick_pkg::*;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] shadow, div_clamped, load_div;
    logic [CNT_W-1:0] tick_count;
    logic             shadow_full, load, accept, counting, to_idle, tick_fire;
    logic             tc, hi, tick_q, slow_en_q, burst_last;

    assign div_clamped = DIV_W'(clamp_div(PKG_DIV_W'(bus.cfg_div)));
    assign counting    = (state != IDLE);
    assign tick_fire   = counting && tc && !bus.stop;
    assign accept      = bus.cfg_valid && !shadow_full;
    assign to_idle     = counting && (state_nxt == IDLE);

`ifdef SLOW_TICK_BURST_EN
    logic [CNT_W-1:0] burst_lim, burst_cnt;
    logic             burst_done_q, enter_run;

    assign enter_run  = (state != RUN) && (state_nxt == RUN);
    assign burst_last = (state == RUN) && (burst_lim != '0) &&
                        (burst_cnt + CNT_W'(1) == burst_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_lim    <= '0;
            burst_cnt    <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= tick_fire && burst_last;
            if (enter_run) begin
                burst_lim <= bus.burst_len;
                burst_cnt <= '0;
            end else if (tick_fire) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.burst_done = burst_done_q;
`else
    assign burst_last = 1'b0;
`endif

    // stop outranks everything; start outranks step.
    always_comb begin
        state_nxt = state;
        if (bus.stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nxt = RUN;
                         else if (bus.step) state_nxt = STEP;
                RUN:     if (tick_fire && burst_last) state_nxt = IDLE;
                STEP:    if (bus.start) state_nxt = RUN;
                         else if (tick_fire) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Idle writes go straight to the period; busy writes wait in the shadow.
    always_comb begin
        load     = 1'b0;
        load_div = div_clamped;
        if (accept && (!counting || to_idle)) begin
            load = 1'b1;
        end else if (shadow_full && (to_idle || tick_fire)) begin
            load     = 1'b1;
            load_div = shadow;
        end
    end

    slow_tick_phase #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_nxt == IDLE),
        .en       (counting),
        .load     (load),
        .load_div (load_div),
        .tc       (tc),
        .hi       (hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            shadow_full <= 1'b0;
            tick_q      <= 1'b0;
            slow_en_q   <= 1'b0;
            tick_count  <= '0;
        end else begin
            state     <= state_nxt;
            tick_q    <= tick_fire;
            slow_en_q <= counting && !bus.stop && hi;

            if (state == IDLE && state_nxt == RUN)
                tick_count <= '0;
            else if (tick_fire)
                tick_count <= tick_count + CNT_W'(1);

            if (to_idle) begin
                shadow_full <= 1'b0;
            end else if (counting && accept) begin
                shadow      <= div_clamped;
                shadow_full <= 1'b1;
            end else if (tick_fire) begin
                shadow_full <= 1'b0;
            end
        end
    end

    assign bus.tick       = tick_q;
    assign bus.slow_en    = slow_en_q;
    assign bus.busy       = counting;
    assign bus.tick_count = tick_count;
    assign bus.cfg_ready  = !shadow_full;

endmodule
